// File: rtl/branch_predictor_if.sv
// Lookup/update/statistics bundle between the fetch/decode pipeline and the
// branch predictor. master = pipeline side, slave = predictor side.
interface branch_predictor_if;
    logic [31:0] pc_i;
    logic        pred_taken_o;
    logic [31:0] pred_target_o;

    logic        upd_valid_i;
    logic [31:0] upd_pc_i;
    logic        upd_taken_i;
    logic [31:0] upd_target_i;
    logic        upd_pred_taken_i;
    logic [31:0] upd_pred_target_i;
    logic        mispredict_o;

    logic [31:0] stat_branches_o;
    logic [31:0] stat_mispred_o;

    modport master (
        output pc_i,
        input  pred_taken_o,
        input  pred_target_o,
        output upd_valid_i,
        output upd_pc_i,
        output upd_taken_i,
        output upd_target_i,
        output upd_pred_taken_i,
        output upd_pred_target_i,
        input  mispredict_o,
        input  stat_branches_o,
        input  stat_mispred_o
    );

    modport slave (
        input  pc_i,
        output pred_taken_o,
        output pred_target_o,
        input  upd_valid_i,
        input  upd_pc_i,
        input  upd_taken_i,
        input  upd_target_i,
        input  upd_pred_taken_i,
        input  upd_pred_target_i,
        output mispredict_o,
        output stat_branches_o,
        output stat_mispred_o
    );
endinterface

// File: rtl/branch_predictor.sv
// Tagged direct-mapped BTB with 2-bit counters, optional gshare indexing.
// Ports: clk_i, rst_i (async high), clear_i (sync flush), bp (slave side).
module branch_predictor #(
    parameter int ENTRIES  = 16,
    parameter int TAG_BITS = 8,
    parameter int MODE     = 0,
    parameter int GHR_BITS = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    branch_predictor_if.slave bp
);
    localparam int IDX_BITS = $clog2(ENTRIES);
    localparam int TAG_LO   = IDX_BITS + 2;
    localparam int TAG_HI   = IDX_BITS + TAG_BITS + 1;

    typedef logic [IDX_BITS-1:0] idx_t;
    typedef logic [TAG_BITS-1:0] tag_t;

    logic        valid_q  [ENTRIES];
    tag_t        tag_q    [ENTRIES];
    logic [31:0] target_q [ENTRIES];
    logic [1:0]  ctr_q    [ENTRIES];

    logic [GHR_BITS-1:0] ghr_q;
    logic [31:0]         branches_q;
    logic [31:0]         mispred_q;

    idx_t hist;
    idx_t l_idx;
    idx_t u_idx;
    tag_t l_tag;
    tag_t u_tag;
    logic l_hit;
    logic u_hit;
    logic pred_taken;
    logic mispredict;
    logic unused_upd_pc;

    // History is folded into the low index bits; bimodal keeps it at zero.
    always_comb begin
        hist = '0;
        if (MODE == 1) begin
            hist[GHR_BITS-1:0] = ghr_q;
        end
    end

    assign l_idx = bp.pc_i[IDX_BITS+1:2] ^ hist;
    assign l_tag = bp.pc_i[TAG_HI:TAG_LO];
    assign l_hit = valid_q[l_idx] && (tag_q[l_idx] == l_tag);

    assign pred_taken       = l_hit && ctr_q[l_idx][1];
    assign bp.pred_taken_o  = pred_taken;
    assign bp.pred_target_o = pred_taken ? target_q[l_idx]
                                         : bp.pc_i + 32'd4;

    assign u_idx = bp.upd_pc_i[IDX_BITS+1:2] ^ hist;
    assign u_tag = bp.upd_pc_i[TAG_HI:TAG_LO];
    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    // Target only matters when the branch was actually taken.
    assign mispredict = bp.upd_valid_i &&
        ((bp.upd_taken_i != bp.upd_pred_taken_i) ||
         (bp.upd_taken_i &&
          (bp.upd_pred_target_i != bp.upd_target_i)));
    assign bp.mispredict_o = mispredict;

    assign bp.stat_branches_o = branches_q;
    assign bp.stat_mispred_o  = mispred_q;

    assign unused_upd_pc = ^bp.upd_pc_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
            ghr_q      <= '0;
            branches_q <= '0;
            mispred_q  <= '0;
        end else begin
            // Stats count every resolution, even one dropped by a clear.
            if (bp.upd_valid_i) begin
                branches_q <= branches_q + 32'd1;
                if (mispredict) begin
                    mispred_q <= mispred_q + 32'd1;
                end
            end

            if (clear_i) begin
                for (int i = 0; i < ENTRIES; i++) begin
                    valid_q[i] <= 1'b0;
                    ctr_q[i]   <= 2'b01;
                end
                ghr_q <= '0;
            end else if (bp.upd_valid_i) begin
                if (u_hit && bp.upd_taken_i) begin
                    if (ctr_q[u_idx] != 2'b11) begin
                        ctr_q[u_idx] <= ctr_q[u_idx] + 2'd1;
                    end
                    target_q[u_idx] <= bp.upd_target_i;
                end else if (u_hit) begin
                    if (ctr_q[u_idx] != 2'b00) begin
                        ctr_q[u_idx] <= ctr_q[u_idx] - 2'd1;
                    end
                end else if (bp.upd_taken_i) begin
                    // Taken miss evicts whatever shares the slot.
                    valid_q[u_idx]  <= 1'b1;
                    tag_q[u_idx]    <= u_tag;
                    target_q[u_idx] <= bp.upd_target_i;
                    ctr_q[u_idx]    <= 2'b10;
                end

                if (MODE == 1) begin
                    ghr_q <= (ghr_q << 1) |
                             GHR_BITS'(bp.upd_taken_i);
                end
            end
        end
    end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised branch prediction unit that lets the IF stage redirect fetch speculatively. Today fetch always falls through and the ID-stage branch unit flushes IF/ID on every taken beq.
- Combinational lookup on the IF PC: taken/not-taken plus target.
- Registered update from the ID-stage branch resolution.
- Tagged direct-mapped BTB with 2-bit saturating counters; optional gshare indexing; resolution statistics counters.

Parameters:
- ENTRIES, 16, number of BTB/counter entries; power of two, ≥2; IDX_BITS = log2(ENTRIES).
- TAG_BITS, 8, PC tag bits stored per entry; IDX_BITS+TAG_BITS+2 ≤ 32.
- MODE, 0, 0 = bimodal (index = PC only); 1 = gshare (index = PC XOR GHR).
- GHR_BITS, 4, global history length; must be ≤ IDX_BITS; unused when MODE=0.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous active-high reset.
- clear_i  in  1  synchronous invalidate of all entries and GHR.
- pc_i  in  32  IF-stage PC to predict.
- pred_taken_o  out  1  predicted taken.
- pred_target_o  out  32  next fetch PC.
- upd_valid_i  in  1  ID stage resolved a branch this cycle.
- upd_pc_i  in  32  PC of the resolved branch.
- upd_taken_i  in  1  actual outcome.
- upd_target_i  in  32  actual taken target (PC+imm).
- upd_pred_taken_i  in  1  prediction made for this branch, carried through IF/ID.
- upd_pred_target_i  in  32  predicted target, carried through IF/ID.
- mispredict_o  out  1  combinational; pipeline flushes and redirects when set.
- stat_branches_o  out  32  resolved-branch count.
- stat_mispred_o  out  32  mispredict count.

Behaviour:
- State per entry: valid (1), tag (TAG_BITS), target (32), ctr (2). Global: GHR (GHR_BITS). Stats: two 32-bit counters.
- Index: idx(pc) = pc[IDX_BITS+1:2], XOR {0, GHR} zero-extended to IDX_BITS when MODE=1. Tag: tag(pc) = pc[IDX_BITS+TAG_BITS+1 : IDX_BITS+2].
- Lookup (0-cycle, combinational):
  - hit = valid[idx(pc_i)] && tag matches tag(pc_i).
  - pred_taken_o = hit && ctr[1].
  - pred_target_o = pred_taken_o ? target : pc_i+4 (mod 2^32).
- Mispredict (combinational): mispredict_o = upd_valid_i && ((upd_taken_i != upd_pred_taken_i) || (upd_taken_i && upd_pred_target_i != upd_target_i)).
- Update, on the rising edge when upd_valid_i and not clear_i; index uses the GHR value before this edge:
  - Hit, taken: ctr saturating +1 (max 11); target <= upd_target_i.
  - Hit, not taken: ctr saturating −1 (min 00); target unchanged.
  - Miss, taken: allocate; overwrite whatever is there: valid=1, tag, target, ctr=10.
  - Miss, not taken: no table change.
  - MODE=1: GHR <= {GHR[GHR_BITS-2:0], upd_taken_i}. MODE=0: GHR held at 0.
  - stat_branches_o +1; stat_mispred_o +1 if mispredict_o. Both wrap modulo 2^32.
- Same-cycle lookup and update to the same index: lookup returns the pre-edge contents (no bypass). The new value is visible the cycle after the edge.
- clear_i: all valid=0, all ctr=01, GHR=0. Overrides a simultaneous update, except that stats still count that update. Stats are not cleared.
- Reset (async, rst_i=1): all valid=0, ctr=01, targets=0, tags=0, GHR=0, stats=0.
  - Outputs during reset: pred_taken_o=0, pred_target_o=pc_i+4, stat_*=0.
  - mispredict_o remains combinational on its inputs.
  - Reset asserted mid-update discards that update.
- Table is flop-based. No multi-cycle operations and no backpressure: one update per cycle max; lookup every cycle.

Test Plan:
- Reset, then pc_i=0x40 -> pred_taken_o=0, pred_target_o=0x44, stat_*=0.
- MODE=0: update pc=0x40 taken target=0x80, pred_taken=0 -> mispredict_o=1. Next cycle pc_i=0x40 -> pred_taken_o=1, target 0x80; stat_branches_o=1, stat_mispred_o=1.
- Counter saturation: from ctr=10, three taken updates -> stays 11. Then not-taken, not-taken -> ctr=01, pred_taken_o=0. Further not-taken -> 00. Allocation on a not-taken miss never occurs.
- Aliasing with ENTRIES=16, TAG_BITS=8: allocate 0x40, then taken update at 0x80 (same idx 0, different tag) -> lookup 0x40 misses (pred_target 0x44), 0x80 hits.
- MODE=1, GHR_BITS=4: updates T,T,N,T -> GHR=1101. A lookup of pc 0x40 then uses idx 0x0^0xD = 0xD. Same-cycle update+lookup at one index -> old prediction, new one next cycle.
- clear_i with concurrent taken update -> all misses afterwards, GHR=0, stat_branches_o incremented. Async rst_i mid-stream -> all state and stats 0 immediately, without waiting for a clock edge.
